// File: rtl/pe_grid_pkg.sv
// Shared constants and operand/partial-sum types for the 12x14 MAC grid.
package pe_grid_pkg;

   localparam int unsigned ROWS   = 12;
   localparam int unsigned COLS   = 14;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned PSUM_W = 32;
   localparam int unsigned TAG_W  = 4;
   localparam int unsigned PROD_W = 2 * DATA_W;

   typedef logic signed [DATA_W-1:0] data_t;
   typedef logic signed [PSUM_W-1:0] psum_t;
   typedef logic [TAG_W-1:0]         tag_t;

endpackage

// File: rtl/pe_grid_if.sv
// Broadcast operand buses plus the per-column partial-sum inputs/outputs of the grid.
interface pe_grid_if;
   import pe_grid_pkg::*;

   data_t image_val_in;
   tag_t  tag_col;
   logic  valid_x;
   data_t weight_val_in;
   tag_t  tag_row;
   logic  valid_y;
   psum_t psum_ins  [0:COLS-1];
   psum_t psum_outs [0:COLS-1];

   modport master (
      output image_val_in, tag_col, valid_x,
      output weight_val_in, tag_row, valid_y,
      output psum_ins,
      input  psum_outs
   );

   modport slave (
      input  image_val_in, tag_col, valid_x,
      input  weight_val_in, tag_row, valid_y,
      input  psum_ins,
      output psum_outs
   );

endinterface

// File: rtl/pe_grid_pe.sv
// One weight/activation-stationary MAC cell: captures tagged broadcasts and
// adds its product to the partial sum passing upward through it.
module pe
   import pe_grid_pkg::*;
#(
   parameter int unsigned ROW_IDX = 0,
   parameter int unsigned COL_IDX = 0
) (
   input  logic  clk,
   input  logic  rst,
   input  data_t image_val_in,
   input  tag_t  tag_col,
   input  logic  valid_x,
   input  data_t weight_val_in,
   input  tag_t  tag_row,
   input  logic  valid_y,
   input  psum_t psum_in,
   output psum_t psum_q
);

   data_t img;
   data_t wt;
   logic  img_v;
   logic  wt_v;

   logic                     ld_x_c;
   logic                     ld_y_c;
   logic                     mac_en_c;
   logic signed [PROD_W-1:0] prod_c;

   // Indices are below 14, so out-of-range tags can never match.
   assign ld_x_c   = valid_x && (tag_col == TAG_W'(COL_IDX));
   assign ld_y_c   = valid_y && (tag_row == TAG_W'(ROW_IDX));
   assign mac_en_c = img_v && wt_v;
   assign prod_c   = PROD_W'(img) * PROD_W'(wt);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         img    <= '0;
         wt     <= '0;
         img_v  <= 1'b0;
         wt_v   <= 1'b0;
         psum_q <= '0;
      end else begin
         if (ld_x_c) begin
            img   <= image_val_in;
            img_v <= 1'b1;
         end
         if (ld_y_c) begin
            wt   <= weight_val_in;
            wt_v <= 1'b1;
         end
         psum_q <= psum_in + (mac_en_c ? PSUM_W'(prod_c) : '0);
      end
   end

endmodule

// File: rtl/pe_grid_12x14.sv
// 12x14 array of MAC cells; operands broadcast by row/column tag, partial sums
// shift from the bottom row to the top row, one register per row.
module pe_grid_12x14
   import pe_grid_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   pe_grid_if.slave  bus
);

   // chain[ROWS] is the bottom input, chain[0] the top output of each column.
   psum_t chain [0:ROWS][0:COLS-1];

   for (genvar c = 0; c < int'(COLS); c++) begin : g_col
      assign chain[ROWS][c]   = bus.psum_ins[c];
      assign bus.psum_outs[c] = chain[0][c];

      for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
         pe #(
            .ROW_IDX (r),
            .COL_IDX (c)
         ) u_pe (
            .clk           (clk),
            .rst           (rst),
            .image_val_in  (bus.image_val_in),
            .tag_col       (bus.tag_col),
            .valid_x       (bus.valid_x),
            .weight_val_in (bus.weight_val_in),
            .tag_row       (bus.tag_row),
            .valid_y       (bus.valid_y),
            .psum_in       (chain[r+1][c]),
            .psum_q        (chain[r][c])
         );
      end
   end

endmodule

// File: tb/tb_pe_grid_12x14.sv
// Directed bench for pe_grid_12x14: expected column outputs are queued with the
// cycle they are due and compared as the grid produces them.
module tb_pe_grid_12x14;
   import pe_grid_pkg::*;

   typedef logic signed [COLS-1:0][PSUM_W-1:0] row_t;
   typedef struct {
      int    cyc;
      string tag;
      row_t  exp;
   } sb_t;

   logic clk = 1'b0;
   logic rst;

   pe_grid_if bus ();

   pe_grid_12x14 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int    cyc;
   int    n_asserts;
   int    n_fail;
   sb_t   sb_q [$];
   data_t img_ref   [COLS];
   bit    img_v_ref [COLS];
   data_t wt_ref    [ROWS];
   bit    wt_v_ref  [ROWS];
   psum_t pin_ref   [COLS];

   // Steady-state column result: psum_in + sum of products of loaded PEs.
   function automatic row_t model();
      row_t m;
      for (int c = 0; c < int'(COLS); c++) begin
         psum_t acc;
         acc = pin_ref[c];
         for (int r = 0; r < int'(ROWS); r++)
            if (img_v_ref[c] && wt_v_ref[r])
               acc = acc + psum_t'(img_ref[c]) * psum_t'(wt_ref[r]);
         m[c] = acc;
      end
      return m;
   endfunction

   task automatic push(input int target, input string tag, input row_t e);
      sb_t s;
      s.cyc = target;
      s.tag = tag;
      s.exp = e;
      sb_q.push_back(s);
   endtask

   task automatic check_due();
      sb_t e;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         e = sb_q.pop_front();
         for (int c = 0; c < int'(COLS); c++) begin
            n_asserts++;
            assert (bus.psum_outs[c] === PSUM_W'(e.exp[c])) else begin
               n_fail++;
               $error("FAIL %s col%0d cyc%0d: observed %0d expected %0d",
                      e.tag, c, cyc, bus.psum_outs[c], $signed(e.exp[c]));
            end
         end
      end
   endtask

   task automatic check_const(input string tag, input int c, input psum_t v);
      n_asserts++;
      assert (bus.psum_outs[c] === v) else begin
         n_fail++;
         $error("FAIL %s col%0d: observed %0d expected %0d", tag, c, bus.psum_outs[c], v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      bus.valid_x = 1'b0;
      bus.valid_y = 1'b0;
      check_due();
   endtask

   task automatic expect_now(input string tag, input row_t e);
      push(cyc, tag, e);
      check_due();
   endtask

   task automatic set_pin(input int c, input psum_t v);
      pin_ref[c]       = v;
      bus.psum_ins[c]  = v;
   endtask

   task automatic load_x(input int tag, input data_t v);
      bus.tag_col      = TAG_W'(tag);
      bus.image_val_in = v;
      bus.valid_x      = 1'b1;
      if (tag < int'(COLS)) begin
         img_ref[tag]   = v;
         img_v_ref[tag] = 1'b1;
      end
   endtask

   task automatic load_y(input int tag, input data_t v);
      bus.tag_row       = TAG_W'(tag);
      bus.weight_val_in = v;
      bus.valid_y       = 1'b1;
      if (tag < int'(ROWS)) begin
         wt_ref[tag]   = v;
         wt_v_ref[tag] = 1'b1;
      end
   endtask

   task automatic clear_model();
      for (int c = 0; c < int'(COLS); c++) begin
         img_ref[c]   = '0;
         img_v_ref[c] = 1'b0;
      end
      for (int r = 0; r < int'(ROWS); r++) begin
         wt_ref[r]   = '0;
         wt_v_ref[r] = 1'b0;
      end
   endtask

   task automatic settle(input string tag);
      repeat (13) step();
      expect_now(tag, model());
   endtask

   // Reset asserted between clock edges; outputs must clear without an edge.
   task automatic async_reset(input int hold);
      #2;
      rst = 1'b0;
      clear_model();
      #1;
      expect_now("rst_immediate", '0);
      repeat (hold) begin
         step();
         expect_now("rst_hold", '0);
      end
      rst = 1'b1;
   endtask

   initial begin
      #100000;
      $error("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      row_t pt;
      cyc       = 0;
      n_asserts = 0;
      n_fail    = 0;
      bus.image_val_in  = '0;
      bus.tag_col       = '0;
      bus.valid_x       = 1'b0;
      bus.weight_val_in = '0;
      bus.tag_row       = '0;
      bus.valid_y       = 1'b0;
      for (int c = 0; c < int'(COLS); c++) set_pin(c, '0);
      clear_model();

      rst = 1'b1;
      #1 rst = 1'b0;
      #1 expect_now("reset_t0", '0);
      repeat (3) begin
         step();
         expect_now("in_reset", '0);
      end
      rst = 1'b1;

      repeat (20) begin
         push(cyc + 1, "idle", '0);
         step();
      end

      // One-cycle pulse must emerge exactly once, 12 edges later.
      for (int i = 0; i < 20; i++) begin
         for (int c = 0; c < int'(COLS); c++) begin
            set_pin(c, (i == 0) ? PSUM_W'(100 + c) : '0);
            pt[c] = (i == 0) ? PSUM_W'(100 + c) : '0;
         end
         push(cyc + 12, "pass_through", pt);
         step();
      end
      repeat (12) step();

      load_x(5, 16'sd10);
      load_y(4, 16'sd1);
      settle("single_mac");
      check_const("single_mac_const", 5, 32'sd10);
      set_pin(5, 32'sd7);
      settle("single_mac_psum7");
      check_const("single_mac_psum7_const", 5, 32'sd17);

      set_pin(5, '0);
      async_reset(2);
      repeat (13) begin
         push(cyc + 1, "post_reset_idle", '0);
         step();
      end

      load_x(0, -16'sd3);
      for (int r = 0; r < int'(ROWS); r++) begin
         load_y(r, DATA_W'(r + 1));
         step();
      end
      settle("col_sum");
      check_const("col_sum_const", 0, -32'sd234);

      load_x(14, 16'sd99);
      load_y(12, 16'sd99);
      step();
      load_x(15, -16'sd7);
      load_y(15, -16'sd7);
      step();
      settle("out_of_range");
      check_const("out_of_range_const", 0, -32'sd234);

      load_x(0, 16'sd2);
      settle("overwrite");
      check_const("overwrite_const", 0, 32'sd156);

      async_reset(2);
      repeat (15) begin
         push(cyc + 1, "after_async_reset", '0);
         step();
      end

      set_pin(0, 32'sd5);
      set_pin(2, 32'sh8000_0000);
      load_x(0, 16'sd2);
      load_y(3, -16'sd5);
      step();
      load_x(2, 16'sh7FFF);
      load_y(5, 16'sh8000);
      step();
      load_x(7, 16'sh8000);
      step();
      settle("signed_wrap");
      check_const("signed_wrap_col7", 7, 32'sd1073905664);

      n_asserts++;
      assert (sb_q.size() == 0) else begin
         n_fail++;
         $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/pe_grid_12x14.md
# pe_grid_12x14

Compute array of 12 rows × 14 columns of multiply-accumulate processing elements (PEs) for the convolution accelerator. Image activations are broadcast on a horizontal bus and captured by every PE in the tagged column. Weights are broadcast on a vertical bus and captured by every PE in the tagged row. Partial sums stream upward through each column, each PE adding its stationary product, and leave at the top as one 32-bit result per column.

## Interface
Parameters:
- ROWS, 12, PE rows.
- COLS, 14, PE columns.
- DATA_W, 16, operand width.
- PSUM_W, 32, partial-sum width.
- TAG_W, 4, row/column tag width.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low: rst=0 clears all state immediately.
- image_val_in  in  DATA_W  activation on the X (horizontal) broadcast bus.
- tag_col  in  TAG_W  destination column for image_val_in.
- valid_x  in  1  qualifies image_val_in/tag_col for one cycle.
- weight_val_in  in  DATA_W  weight on the Y (vertical) broadcast bus.
- tag_row  in  TAG_W  destination row for weight_val_in.
- valid_y  in  1  qualifies weight_val_in/tag_row for one cycle.
- psum_ins[0:COLS-1]  in  PSUM_W each  partial sums entering the bottom row (row ROWS-1) of each column.
- psum_outs[0:COLS-1]  out  PSUM_W each  partial sums leaving the top row (row 0) of each column.

## Operation
- Each PE[r][c] holds the following state:
  - img (DATA_W) and img_v.
  - wt (DATA_W) and wt_v.
  - psum_q (PSUM_W).
- Image load: valid_x=1 and tag_col==c writes image_val_in into img of every PE in column c and sets img_v.
- Weight load: valid_y=1 and tag_row==r writes weight_val_in into wt of every PE in row r and sets wt_v.
- X and Y loads are independent and may occur in the same cycle.
- Out-of-range tags (tag_col ≥ COLS, tag_row ≥ ROWS) load nothing.
- A later load to the same column or row overwrites the earlier value. The valid flag stays set.
- Arithmetic: operands are two's-complement signed.
  - The product is the full 2·DATA_W signed value, sign-extended to PSUM_W.
  - The addition wraps modulo 2^PSUM_W; there is no saturation.
- Psum chain:
  - PE[ROWS-1][c] takes its psum input from psum_ins[c].
  - PE[r][c] takes its psum input from PE[r+1][c].psum_q.
  - psum_outs[c] = PE[0][c].psum_q.
- Every cycle, each PE computes psum_q ← psum_in + ((img_v && wt_v) ? img·wt : 0).
- Accumulation is continuous. The operands are stationary, and a loaded PE adds its product to every psum passing through it.

## Timing
- Reset (rst=0): every img, wt and psum_q clears to 0, and every img_v and wt_v clears to 0.
  - psum_outs are all 0 during reset and until data propagates.
  - Reset asserted mid-operation discards all loaded operands and in-flight sums.
- An operand presented with its valid bit at rising edge k is stored at edge k. The PE uses it in the sum it registers at edge k+1.
- Psum latency is ROWS = 12 cycles: psum_ins[c] sampled at edge k appears on psum_outs[c] after edge k+11, i.e. one register per row.
- Steady state: with psum_ins constant and operands unchanged for ≥12 cycles, psum_outs[c] = psum_ins[c] + Σ_r (img_v&&wt_v ? img[r][c]·wt[r][c] : 0).
- The bus has no backpressure or handshake. The grid accepts one X and one Y broadcast every cycle.

## Structure
- Shared package `pe_grid_pkg`:
  - constants ROWS, COLS, DATA_W, PSUM_W, TAG_W;
  - typedefs data_t (signed DATA_W) and psum_t (signed PSUM_W).
- One sub-module, `pe`. It contains:
  - tag compare against its own row/column indices (passed as parameters);
  - operand registers and valid flags;
  - the multiplier and the psum register.
- The top level instantiates ROWS×COLS `pe` instances in a generate loop. It wires the broadcast buses to every PE and the psum chain bottom-to-top.

## Test plan
- Reset/idle: hold rst=0, then release; drive psum_ins all 0 with no valids for 20 cycles → psum_outs stay all 0.
- Pass-through latency: no operands loaded; psum_ins[c]=100+c for a single cycle, then 0 → psum_outs[c]=100+c for exactly one cycle, 12 edges later; all other cycles 0.
- Single MAC: image 10 to tag_col 5, weight 1 to tag_row 4, psum_ins 0 → after ≤12 cycles psum_outs[5]=10 steadily; other columns 0. Then set psum_ins[5]=7 → psum_outs[5]=17.
- Column sum and signs: image −3 to column 0; weights 1..12 to rows 0..11 → psum_outs[0]=−3·78=−234; columns 1..13 remain 0 because their img_v is clear.
- Out-of-range tags and overwrite:
  - tag_col 14 and tag_row 12 broadcasts → no change to any output.
  - Reloading column 0 with image 2 → psum_outs[0] converges to 156.
- Async reset mid-stream: assert rst=0 between clock edges during the column-sum test → psum_outs drop to 0 immediately and remain 0 after release until operands are reloaded.
